if_prefetch: RTL

Instruction prefetch unit sitting between instruction memory and the `if_id` pipeline register, replacing direct PC-to-ROM addressing at the front of the core. It issues sequential fetch requests ahead of the pipeline and buffers returned `{pc, inst}` pairs in a small FIFO. It presents one instruction per cycle to `if_id` under a valid/ready handshake. Redirects from `ctrl` (`jump_flag`/`jump_addr`) flush the buffer and discard stale in-flight responses.

---
 rtl/if_prefetch_pkg.sv | 21 ++
 rtl/if_prefetch_fifo.sv | 55 +++++
 rtl/if_prefetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package if_prefetch_pkg;

    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    // addi x0, x0, 0 : presented whenever no instruction is valid
    localparam InstBus INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        PF_BOOT  = 2'd0,
        PF_RUN   = 2'd1,
        PF_FLUSH = 2'd2
    } pf_state_e;

    // Sequential instruction address; wraps modulo 2^32
    function automatic InstAddrBus pc_next(input InstAddrBus pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// pf_fifo: small synchronous FIFO holding {pc, inst} pairs.
// The head entry is read straight from storage so a pushed entry is
// visible on the cycle after the push. Clear wins over push and pop.
module pf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) store[wr_ptr] <= wdata;
    end

    assign head  = store[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch unit between instruction memory and
// the if_id register. Issues sequential fetches under a credit limit of
// DEPTH (buffered + in flight), buffers responses and presents one
// instruction per cycle. A redirect flushes the buffer and drops every
// response still in flight for the old stream.
// Optional build macro IF_PREFETCH_BYPASS_EN: a response arriving while
// the buffer is empty is presented in the same cycle.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter InstAddrBus RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       jump_flag,
    input  InstAddrBus jump_addr,
    output logic       mem_req,
    output InstAddrBus mem_addr,
    input  logic       mem_ready,
    input  logic       mem_rvalid,
    input  InstBus     mem_rdata,
    output logic       if_valid,
    output InstAddrBus if_pc,
    output InstBus     if_inst,
    input  logic       if_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    pf_state_e  state, state_next;
    InstAddrBus fetch_pc;
    InstAddrBus resp_pc;
    logic [CW-1:0] outstanding, outst_next;
    logic [CW-1:0] discard, discard_next;

    logic [CW-1:0] fifo_count;
    logic [63:0]   fifo_head;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;

    logic       accept;
    logic       ret;
    logic       run_resp;
    logic       credit_ok;
    logic       pres_valid;
    InstAddrBus pres_pc;
    InstBus     pres_inst;

    // Buffered plus in-flight entries never exceed DEPTH, so the FIFO
    // cannot overflow.
    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    assign mem_req    = (state == PF_RUN) && credit_ok;
    assign mem_addr   = fetch_pc;
    assign accept     = mem_req && mem_ready;
    // A response only counts against a request that is actually in flight.
    assign ret        = mem_rvalid && (outstanding != '0);
    assign run_resp   = (state == PF_RUN) && ret && !jump_flag;
    assign outst_next = outstanding + CW'(accept) - CW'(ret);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= PF_BOOT;
        else      state <= state_next;
    end

    // Next state and drop counter; a redirect reloads the drop count with
    // everything still in flight after this cycle, from any state.
    always_comb begin
        state_next   = state;
        discard_next = discard;
        case (state)
            PF_BOOT:  state_next = PF_RUN;
            PF_RUN:   state_next = PF_RUN;
            PF_FLUSH: begin
                if (ret) discard_next = discard - CW'(1);
                if (discard_next == '0) state_next = PF_RUN;
            end
            default:  state_next = PF_BOOT;
        endcase
        if (jump_flag) begin
            discard_next = outst_next;
            state_next   = (outst_next != '0) ? PF_FLUSH : PF_RUN;
        end
    end

    // Fetch/response address tracking and in-flight counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outst_next;
            discard     <= discard_next;
            if (jump_flag)   fetch_pc <= jump_addr;
            else if (accept) fetch_pc <= pc_next(fetch_pc);
            if (jump_flag)     resp_pc <= jump_addr;
            else if (run_resp) resp_pc <= pc_next(resp_pc);
        end
    end

`ifdef IF_PREFETCH_BYPASS_EN
    logic bypass;
    // With an empty buffer the live response is shown directly and is only
    // stored when the consumer does not take it this cycle.
    assign bypass     = run_resp && fifo_empty;
    assign pres_valid = (!fifo_empty || bypass) && !jump_flag;
    assign pres_pc    = fifo_empty ? resp_pc   : fifo_head[63:32];
    assign pres_inst  = fifo_empty ? mem_rdata : fifo_head[31:0];
    assign fifo_push  = run_resp && !(bypass && if_ready);
`else
    assign pres_valid = !fifo_empty && !jump_flag;
    assign pres_pc    = fifo_head[63:32];
    assign pres_inst  = fifo_head[31:0];
    assign fifo_push  = run_resp;
`endif

    // A redirect cycle never consumes: the buffer is being cleared anyway.
    assign fifo_pop = !fifo_empty && !jump_flag && if_ready;

    assign if_valid = pres_valid;
    assign if_pc    = pres_valid ? pres_pc   : '0;
    assign if_inst  = pres_valid ? pres_inst : INST_NOP;

    pf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (jump_flag),
        .wdata ({resp_pc, mem_rdata}),
        .count (fifo_count),
        .head  (fifo_head),
        .empty (fifo_empty)
    );

endmodule
